// File: rtl/jump_branch_unit_pkg.sv
// Shared core constants for the execute-stage control-transfer unit:
// opcodes, branch funct3 codes and the squash FSM state type.
package jump_branch_unit_pkg;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

endpackage

// File: rtl/jump_branch_unit_branch_cmp.sv
// Combinational B-type condition evaluator; funct3 010/011 are flagged illegal.
module branch_cmp
   import jump_branch_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            take,
   output logic            illegal
);

   always_comb begin
      take    = 1'b0;
      illegal = 1'b0;
      case (funct3)
         F3_BEQ:  take = (rs1 == rs2);
         F3_BNE:  take = (rs1 != rs2);
         F3_BLT:  take = ($signed(rs1) <  $signed(rs2));
         F3_BGE:  take = ($signed(rs1) >= $signed(rs2));
         F3_BLTU: take = (rs1 <  rs2);
         F3_BGEU: take = (rs1 >= rs2);
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/jump_branch_unit.sv
// Resolves JAL/JALR/B-type transfers, registers redirect/link results and
// sequences the squash of younger slots after a taken, aligned transfer.
module jump_branch_unit
   import jump_branch_unit_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int FLUSH_SLOTS = 2,
   parameter int IALIGN      = 32
) (
   input  logic            iCLK,
   input  logic            iRST_N,
   input  logic            iVALID,
   input  logic [31:0]     iIR,
   input  logic [XLEN-1:0] iPC,
   input  logic [XLEN-1:0] iRS1,
   input  logic [XLEN-1:0] iRS2,
   output logic [4:0]      oRD,
   output logic [XLEN-1:0] oREG_IN,
   output logic            oWE,
   output logic            oREDIRECT,
   output logic [XLEN-1:0] oPCBR,
   output logic            oFLUSH,
   output logic            oMISALIGN,
   output logic            oILLEGAL
);

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_SLOTS);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rd;
   logic [XLEN-1:0] imm_j, imm_i, imm_b;
   logic [XLEN-1:0] tgt_jal, tgt_jalr_sum, tgt_jalr, tgt_br, link;
   logic            br_take, br_illegal;

   state_e          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] reg_in_q, reg_in_d, pcbr_q, pcbr_d;
   logic            we_q, we_d, redirect_q, redirect_d, flush_q, flush_d;
   logic            misalign_q, misalign_d, illegal_q, illegal_d;

   logic            accept, is_jal, is_jalr, is_br, taken, mis;
   logic [XLEN-1:0] target;

   assign opcode = iIR[6:0];
   assign funct3 = iIR[14:12];
   assign rd     = iIR[11:7];

   assign imm_j = {{(XLEN-21){iIR[31]}}, iIR[31], iIR[19:12], iIR[20], iIR[30:21], 1'b0};
   assign imm_i = {{(XLEN-12){iIR[31]}}, iIR[31:20]};
   assign imm_b = {{(XLEN-13){iIR[31]}}, iIR[31], iIR[7], iIR[30:25], iIR[11:8], 1'b0};

   assign tgt_jal      = iPC + imm_j;
   assign tgt_jalr_sum = iRS1 + imm_i;
   assign tgt_jalr     = {tgt_jalr_sum[XLEN-1:1], 1'b0};
   assign tgt_br       = iPC + imm_b;
   assign link         = iPC + XLEN'(4);

   branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
      .funct3  (funct3),
      .rs1     (iRS1),
      .rs2     (iRS2),
      .take    (br_take),
      .illegal (br_illegal)
   );

   always_comb begin
      accept  = (state_q == ST_IDLE) && iVALID;
      is_jal  = (opcode == OP_JAL);
      is_jalr = (opcode == OP_JALR) && (funct3 == 3'b000);
      is_br   = (opcode == OP_BRANCH);
      taken   = accept && (is_jal || is_jalr || (is_br && br_take));
      if (is_jal)
         target = tgt_jal;
      else if (is_jalr)
         target = tgt_jalr;
      else
         target = tgt_br;
   end

   // 16-bit alignment only requires an even target
   if (IALIGN == 16) begin : g_align16
      assign mis = target[0];
   end else begin : g_align32
      assign mis = (target[1:0] != 2'b00);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (taken && !mis) begin
               state_d = ST_FLUSH;
               cnt_d   = FLUSH_INIT;
            end
         end
         default: begin
            if (cnt_q <= 3'd1) begin
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
      endcase

      flush_d    = (state_d == ST_FLUSH);
      redirect_d = taken && !mis;
      misalign_d = taken && mis;
      illegal_d  = accept && is_br && br_illegal;
      we_d       = accept && (is_jal || is_jalr) && (rd != 5'd0) && !mis;
      pcbr_d     = redirect_d ? target : pcbr_q;
      reg_in_d   = (accept && (is_jal || is_jalr)) ? link : reg_in_q;
      rd_d       = (accept && (is_jal || is_jalr)) ? rd : rd_q;
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 3'd0;
         rd_q       <= 5'd0;
         reg_in_q   <= '0;
         pcbr_q     <= '0;
         we_q       <= 1'b0;
         redirect_q <= 1'b0;
         flush_q    <= 1'b0;
         misalign_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         reg_in_q   <= reg_in_d;
         pcbr_q     <= pcbr_d;
         we_q       <= we_d;
         redirect_q <= redirect_d;
         flush_q    <= flush_d;
         misalign_q <= misalign_d;
         illegal_q  <= illegal_d;
      end
   end

   assign oRD       = rd_q;
   assign oREG_IN   = reg_in_q;
   assign oWE       = we_q;
   assign oREDIRECT = redirect_q;
   assign oPCBR     = pcbr_q;
   assign oFLUSH    = flush_q;
   assign oMISALIGN = misalign_q;
   assign oILLEGAL  = illegal_q;

endmodule

// File: tb/tb_jump_branch_unit.sv
// Scoreboard bench: two instances (IALIGN 32 and 16) driven in lockstep.
module tb_jump_branch_unit;

   localparam int FS = 2;
   localparam int K_JAL = 0, K_JALR = 1, K_BR = 2, K_NONE = 3;

   typedef struct packed {
      logic        redirect;
      logic        we;
      logic        misalign;
      logic        illegal;
      logic        flush;
      logic [31:0] pcbr;
      logic [31:0] reg_in;
      logic [4:0]  rd;
   } exp_t;

   logic        clk, rst_n, vld;
   logic [31:0] ir, pc, rs1, rs2;
   logic [4:0]  a_rd, b_rd;
   logic [31:0] a_reg_in, b_reg_in, a_pcbr, b_pcbr;
   logic        a_we, b_we, a_redir, b_redir, a_flush, b_flush;
   logic        a_mis, b_mis, a_ill, b_ill;

   exp_t q32[$];
   exp_t q16[$];
   int   checks = 0;
   int   errors = 0;
   int   cnt32 = 0;
   int   cnt16 = 0;
   int   txn = 0;

   jump_branch_unit #(.XLEN(32), .FLUSH_SLOTS(FS), .IALIGN(32)) dut_a (
      .iCLK(clk), .iRST_N(rst_n), .iVALID(vld), .iIR(ir), .iPC(pc),
      .iRS1(rs1), .iRS2(rs2), .oRD(a_rd), .oREG_IN(a_reg_in), .oWE(a_we),
      .oREDIRECT(a_redir), .oPCBR(a_pcbr), .oFLUSH(a_flush),
      .oMISALIGN(a_mis), .oILLEGAL(a_ill)
   );

   jump_branch_unit #(.XLEN(32), .FLUSH_SLOTS(FS), .IALIGN(16)) dut_b (
      .iCLK(clk), .iRST_N(rst_n), .iVALID(vld), .iIR(ir), .iPC(pc),
      .iRS1(rs1), .iRS2(rs2), .oRD(b_rd), .oREG_IN(b_reg_in), .oWE(b_we),
      .oREDIRECT(b_redir), .oPCBR(b_pcbr), .oFLUSH(b_flush),
      .oMISALIGN(b_mis), .oILLEGAL(b_ill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_j(input logic [4:0] rd, input int imm);
      logic [31:0] t = imm;
      return {t[20], t[10:1], t[11], t[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_i(input logic [4:0] rd, input int imm, input logic [2:0] f3);
      logic [31:0] t = imm;
      return {t[11:0], 5'd0, f3, rd, 7'b1100111};
   endfunction

   function automatic logic [31:0] enc_b(input logic [2:0] f3, input int imm);
      logic [31:0] t = imm;
      return {t[12], t[10:5], 5'd2, 5'd1, f3, t[4:1], t[11], 7'b1100011};
   endfunction

   // Reference: immediate and kind come from the stimulus, not from decoding ir.
   task automatic model_step(input int ialign, inout int cnt, input int kind, input int imm,
                             output exp_t e);
      logic        acc, tk;
      logic [31:0] tgt;
      logic [2:0]  f3;
      e   = '0;
      tk  = 1'b0;
      tgt = 32'd0;
      f3  = ir[14:12];
      if (cnt > 0) begin
         cnt--;
         acc = 1'b0;
      end else begin
         acc = vld;
      end
      if (acc) begin
         case (kind)
            K_JAL:  begin tk = 1'b1; tgt = pc + 32'(imm); end
            K_JALR: begin tk = 1'b1; tgt = (rs1 + 32'(imm)) & 32'hFFFF_FFFE; end
            K_BR: begin
               tgt = pc + 32'(imm);
               case (f3)
                  3'd0: tk = (rs1 == rs2);
                  3'd1: tk = (rs1 != rs2);
                  3'd4: tk = ($signed(rs1) <  $signed(rs2));
                  3'd5: tk = ($signed(rs1) >= $signed(rs2));
                  3'd6: tk = (rs1 <  rs2);
                  3'd7: tk = (rs1 >= rs2);
                  default: e.illegal = 1'b1;
               endcase
            end
            default: ;
         endcase
         e.misalign = tk && ((ialign == 32) ? (tgt[1:0] != 2'b00) : tgt[0]);
         e.redirect = tk && !e.misalign;
         e.pcbr     = tgt;
         e.we       = (kind == K_JAL || kind == K_JALR) && (ir[11:7] != 5'd0) && !e.misalign;
         e.reg_in   = pc + 32'd4;
         e.rd       = ir[11:7];
         if (e.redirect) cnt = FS;
      end
      e.flush = (cnt > 0);
   endtask

   task automatic cmp_out(input string tag, input exp_t e, input logic r, input logic w,
                          input logic m, input logic il, input logic f, input logic [31:0] pcbr,
                          input logic [31:0] regin, input logic [4:0] rd);
      check({tag, ".redirect"}, 32'(r),  32'(e.redirect));
      check({tag, ".we"},       32'(w),  32'(e.we));
      check({tag, ".misalign"}, 32'(m),  32'(e.misalign));
      check({tag, ".illegal"},  32'(il), 32'(e.illegal));
      check({tag, ".flush"},    32'(f),  32'(e.flush));
      if (e.redirect) check({tag, ".pcbr"}, pcbr, e.pcbr);
      if (e.we) begin
         check({tag, ".reg_in"}, regin, e.reg_in);
         check({tag, ".rd"},     32'(rd), 32'(e.rd));
      end
   endtask

   task automatic do_cycle(input string name, input logic v, input logic [31:0] instr,
                           input int kind, input int imm, input logic [31:0] pc_v,
                           input logic [31:0] rs1_v, input logic [31:0] rs2_v);
      exp_t e;
      @(negedge clk);
      vld = v; ir = instr; pc = pc_v; rs1 = rs1_v; rs2 = rs2_v;
      model_step(32, cnt32, kind, imm, e);
      q32.push_back(e);
      model_step(16, cnt16, kind, imm, e);
      q16.push_back(e);
      @(posedge clk);
      #1;
      e = q32.pop_front();
      cmp_out({name, "/a32"}, e, a_redir, a_we, a_mis, a_ill, a_flush, a_pcbr, a_reg_in, a_rd);
      e = q16.pop_front();
      cmp_out({name, "/b16"}, e, b_redir, b_we, b_mis, b_ill, b_flush, b_pcbr, b_reg_in, b_rd);
      txn++;
      $display("txn %0d %s v=%0b ir=%08h pc=%08h | a: rd=%0b pcbr=%08h fl=%0b mis=%0b ill=%0b | b: rd=%0b pcbr=%08h fl=%0b mis=%0b",
               txn, name, v, instr, pc_v, a_redir, a_pcbr, a_flush, a_mis, a_ill,
               b_redir, b_pcbr, b_flush, b_mis);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".a_rd"},     32'(a_rd), 32'd0);
      check({tag, ".a_reg_in"}, a_reg_in,  32'd0);
      check({tag, ".a_pcbr"},   a_pcbr,    32'd0);
      check({tag, ".a_pulses"}, 32'({a_we, a_redir, a_flush, a_mis, a_ill}), 32'd0);
      check({tag, ".b_rd"},     32'(b_rd), 32'd0);
      check({tag, ".b_reg_in"}, b_reg_in,  32'd0);
      check({tag, ".b_pcbr"},   b_pcbr,    32'd0);
      check({tag, ".b_pulses"}, 32'({b_we, b_redir, b_flush, b_mis, b_ill}), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; vld = 1'b0; ir = 32'd0; pc = 32'd0; rs1 = 32'd0; rs2 = 32'd0;
      #1;
      check_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // JAL x1 then two squashed valid slots
      do_cycle("jal",      1'b1, enc_j(5'd1, 32'h20), K_JAL, 32'h20, 32'h100, 32'd0, 32'd0);
      do_cycle("squash1",  1'b1, enc_j(5'd2, 32'h40), K_JAL, 32'h40, 32'h104, 32'd0, 32'd0);
      do_cycle("squash2",  1'b1, enc_j(5'd3, 32'h40), K_JAL, 32'h40, 32'h108, 32'd0, 32'd0);
      do_cycle("jal_neg",  1'b1, enc_j(5'd7, -32'sd16), K_JAL, -16, 32'h500, 32'd0, 32'd0);
      do_cycle("idle1",    1'b0, 32'd0, K_NONE, 0, 32'd0, 32'd0, 32'd0);
      do_cycle("idle2",    1'b0, 32'd0, K_NONE, 0, 32'd0, 32'd0, 32'd0);

      do_cycle("jalr_x0",  1'b1, enc_i(5'd0, -2, 3'b000), K_JALR, -2, 32'h400, 32'h203, 32'd0);
      do_cycle("idle3",    1'b0, 32'd0, K_NONE, 0, 32'd0, 32'd0, 32'd0);
      do_cycle("idle4",    1'b0, 32'd0, K_NONE, 0, 32'd0, 32'd0, 32'd0);

      do_cycle("blt",      1'b1, enc_b(3'd4, 16), K_BR, 16, 32'h200, 32'hFFFF_FFFF, 32'd1);
      do_cycle("idle5",    1'b0, 32'd0, K_NONE, 0, 32'd0, 32'd0, 32'd0);
      do_cycle("idle6",    1'b0, 32'd0, K_NONE, 0, 32'd0, 32'd0, 32'd0);
      // not-taken branches back-to-back, then a taken one the very next cycle
      do_cycle("bltu_nt",  1'b1, enc_b(3'd6, 16), K_BR, 16, 32'h210, 32'hFFFF_FFFF, 32'd1);
      do_cycle("beq_nt",   1'b1, enc_b(3'd0, 8),  K_BR, 8,  32'h214, 32'd5, 32'd6);
      do_cycle("bgeu_nt",  1'b1, enc_b(3'd7, 8),  K_BR, 8,  32'h218, 32'd0, 32'd1);
      do_cycle("bge_nt",   1'b1, enc_b(3'd5, 8),  K_BR, 8,  32'h21C, 32'h8000_0000, 32'd1);
      do_cycle("bne_tk",   1'b1, enc_b(3'd1, -64), K_BR, -64, 32'h220, 32'd5, 32'd6);
      do_cycle("idle7",    1'b0, 32'd0, K_NONE, 0, 32'd0, 32'd0, 32'd0);
      do_cycle("idle8",    1'b0, 32'd0, K_NONE, 0, 32'd0, 32'd0, 32'd0);

      do_cycle("beq_p6",   1'b1, enc_b(3'd0, 6), K_BR, 6, 32'h300, 32'd9, 32'd9);
      do_cycle("idle9",    1'b0, 32'd0, K_NONE, 0, 32'd0, 32'd0, 32'd0);
      do_cycle("idle10",   1'b0, 32'd0, K_NONE, 0, 32'd0, 32'd0, 32'd0);

      do_cycle("ill_010",  1'b1, enc_b(3'd2, 8), K_BR, 8, 32'h320, 32'd1, 32'd1);
      do_cycle("ill_011",  1'b1, enc_b(3'd3, 8), K_BR, 8, 32'h324, 32'd1, 32'd2);
      do_cycle("addi",     1'b1, 32'h0010_0093, K_NONE, 0, 32'h328, 32'd0, 32'd0);
      do_cycle("jalr_f3",  1'b1, enc_i(5'd1, 8, 3'b001), K_NONE, 0, 32'h32C, 32'h100, 32'd0);
      do_cycle("jal_mis",  1'b1, enc_j(5'd4, 6), K_JAL, 6, 32'h330, 32'd0, 32'd0);
      do_cycle("idle11",   1'b0, 32'd0, K_NONE, 0, 32'd0, 32'd0, 32'd0);
      do_cycle("idle12",   1'b0, 32'd0, K_NONE, 0, 32'd0, 32'd0, 32'd0);

      // wrap-around JAL, then reset in the middle of its flush window
      do_cycle("jal_wrap", 1'b1, enc_j(5'd5, 8), K_JAL, 8, 32'hFFFF_FFFC, 32'd0, 32'd0);
      vld = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("flush_rst");
      cnt32 = 0;
      cnt16 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      do_cycle("jal_post", 1'b1, enc_j(5'd6, 32'h80), K_JAL, 32'h80, 32'h600, 32'd0, 32'd0);
      do_cycle("idle13",   1'b0, 32'd0, K_NONE, 0, 32'd0, 32'd0, 32'd0);
      do_cycle("idle14",   1'b0, 32'd0, K_NONE, 0, 32'd0, 32'd0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jump_branch_unit.md
# jump_branch_unit

Execute-stage control-transfer unit for the RISC-V core. It resolves JAL, JALR and all six B-type conditional branches and produces an absolute redirect target and the link value. It also owns the pipeline squash sequence after a taken transfer, replacing the fixed-offset, single-instruction-type J unit. It sits between the register-file read stage and PC/fetch control, and all of its outputs are registered.

## Interface
- XLEN, 32: datapath width (32 or 64)
- FLUSH_SLOTS, 2: younger pipeline slots squashed after a taken transfer (1..7)
- IALIGN, 32: instruction alignment in bits; 32 checks target[1:0], 16 checks target[0] only

- iCLK  in  1  clock; all state updates on its rising edge
- iRST_N  in  1  reset, asynchronous, active-low
- iVALID  in  1  iIR/iPC/iRS1/iRS2 hold a valid execute-stage instruction
- iIR  in  32  instruction word
- iPC  in  XLEN  PC of iIR
- iRS1  in  XLEN  rs1 operand
- iRS2  in  XLEN  rs2 operand
- oRD  out  5  destination register of the accepted JAL/JALR
- oREG_IN  out  XLEN  link value, iPC+4
- oWE  out  1  write oREG_IN to oRD this cycle
- oREDIRECT  out  1  one-cycle pulse: fetch must load oPCBR
- oPCBR  out  XLEN  absolute redirect target
- oFLUSH  out  1  younger slots are being squashed
- oMISALIGN  out  1  one-cycle pulse: taken target misaligned, exception
- oILLEGAL  out  1  one-cycle pulse: branch opcode with funct3 010/011

## Operation
- Decode: opcode 1101111 = JAL, 1100111 with funct3 000 = JALR, 1100011 = BRANCH. Any other opcode is ignored, and all outputs pulse low.
- Immediates are sign-extended to XLEN:
  - J: {ir[31],ir[19:12],ir[20],ir[30:21],0}
  - I: ir[31:20]
  - B: {ir[31],ir[7],ir[30:25],ir[11:8],0}
- Targets:
  - JAL: iPC+immJ
  - JALR: (iRS1+immI) with bit 0 cleared
  - BRANCH: iPC+immB
  - All sums wrap modulo 2^XLEN.
- Conditions:
  - BEQ / BNE: ==, !=
  - BLT / BGE: signed <, >=
  - BLTU / BGEU: unsigned <, >=
- Taken: JAL, JALR, or a branch whose condition holds.
- Link: oREG_IN = iPC+4 (wraps). oWE = 1 only for an accepted JAL/JALR with rd != 0 and an aligned target.
- Misaligned taken target: oMISALIGN = 1. No oREDIRECT, no oWE, no flush. Not-taken branches never raise oMISALIGN.
- FSM with 2 states: IDLE and FLUSH, plus a 3-bit counter.
  - IDLE: an instruction is accepted when iVALID=1. On a taken, aligned transfer, go to FLUSH with counter = FLUSH_SLOTS.
  - FLUSH: oFLUSH=1 and iVALID is ignored (those slots are squashed). The counter decrements each cycle; go back to IDLE when it reaches 1.
- Not-taken branch, misaligned transfer, or illegal funct3: stay in IDLE. The next instruction is accepted the following cycle.

## Timing
- Reset values (asynchronous on iRST_N=0): state IDLE, counter 0, and every output 0, including oPCBR, oREG_IN and oRD.
- Latency is 1 cycle. An instruction accepted at edge N drives oREDIRECT/oPCBR/oWE/oREG_IN/oRD/oMISALIGN/oILLEGAL during cycle N+1, and all pulses are exactly 1 cycle wide.
- oFLUSH is high in cycles N+1 .. N+FLUSH_SLOTS. The next acceptance can occur at edge N+FLUSH_SLOTS+1.
- Back-to-back not-taken branches are accepted every cycle.
- oPCBR and oREG_IN hold their last values when no pulse is active. Consumers qualify them with oREDIRECT/oWE.
- Reset asserted during FLUSH aborts immediately: outputs clear, and the first acceptance is allowed on the first edge after deassertion.
- iVALID=0 in IDLE: no state change, and pulse outputs are 0.

## Structure
- The shared core package holds:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH
  - funct3 constants F3_BEQ..F3_BGEU
  - the FSM state enum
- Sub-module: branch_cmp, purely combinational. Inputs are funct3, rs1 and rs2; outputs are take and illegal. It is instantiated once.
- Immediate extraction, target adders and alignment check stay in the top module.

## Test plan
- JAL, rd=x1, iPC=0x100, immJ=+0x20 -> cycle N+1: oREDIRECT=1, oPCBR=0x120, oWE=1, oREG_IN=0x104. oFLUSH is high for 2 cycles, and iVALID during those cycles is ignored.
- JALR, rd=x0, iRS1=0x203, immI=-2 -> oPCBR=0x200 (bit 0 cleared, bit 1 clear so aligned), oREDIRECT=1, oWE=0.
- BLT with iRS1=0xFFFFFFFF, iRS2=1 -> taken. BLTU with the same operands -> not taken, no flush, and the next instruction is accepted at N+1.
- BEQ taken to iPC+6 with IALIGN=32 -> oMISALIGN=1, no redirect, no flush. Repeated with IALIGN=16 -> oREDIRECT=1, oPCBR=iPC+6.
- Branch with funct3=010 -> oILLEGAL pulse only.
- JAL at iPC=0xFFFFFFFC with immJ=+8 -> oPCBR=0x4, oREG_IN=0x0 (wrap). iRST_N pulsed low during FLUSH -> all outputs 0 immediately; a JAL presented after release is accepted.
